fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the LEGv8 core; sits directly upstream of the 64-word instruction ROM (imem).
- Owns the program counter and drives the ROM word address. Registers the returned word into a fetch/decode pipeline register with a valid flag.
- Handles decode-stage stall, execute-stage branch redirect with flush, halt on an all-zero word, and fault on an illegal PC.

Parameters:
- N, 64, PC and branch-target width in bits.
- IMEM_WORDS_LOG2, 6, ROM word-address width; ROM spans 4*2^IMEM_WORDS_LOG2 bytes.
- RESET_PC, 0, PC value loaded on reset (must be word aligned).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- stall  input  1  decode not ready; hold PC and pipeline register.
- branch_taken  input  1  redirect request from execute.
- branch_target  input  N  byte address of redirect.
- imem_addr  output  IMEM_WORDS_LOG2  word address to ROM; combinational, equals pc[IMEM_WORDS_LOG2+1:2].
- imem_q  input  32  instruction word from ROM; combinational read, same cycle.
- instr  output  32  registered instruction to decode.
- instr_pc  output  N  registered PC of instr.
- instr_valid  output  1  instr/instr_pc hold a real instruction this cycle.
- halted  output  1  fetch stopped on a zero word.
- fault  output  1  fetch stopped on an illegal PC.

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC, state=BOOT.
  - instr=0, instr_pc=0, instr_valid=0, halted=0, fault=0.
- BOOT: one cycle with no fetch and instr_valid=0, then RUN.
- RUN, per-edge priority branch_taken > stall > fetch:
  - Branch:
    - If branch_target[1:0]!=0 or branch_target >= 4*2^IMEM_WORDS_LOG2: state=FAULT, instr_valid=0.
    - Otherwise: pc=branch_target, instr_valid=0 (one-cycle bubble flushes the wrong-path word); stall is ignored in this cycle.
  - Stall: pc, instr, instr_pc and instr_valid all hold.
  - Fetch:
    - If pc >= 4*2^IMEM_WORDS_LOG2: state=FAULT, instr_valid=0, pc unchanged.
    - Else if imem_q==32'h0: state=HALT, instr_valid=0; the zero word is not issued and pc is unchanged.
    - Else: instr=imem_q, instr_pc=pc, instr_valid=1, pc=pc+4 (N-bit wrap, never reached because of the range check).
- HALT: halted=1, instr_valid=0. branch_taken and stall are ignored. Exits only on reset.
- FAULT: fault=1, instr_valid=0. All inputs are ignored. Exits only on reset.
- halted and fault are registered; they assert on the edge that enters the state and are never both 1.
- Latency: ROM word at PC p appears on instr one edge after imem_addr=p[7:2], provided no stall or branch occurs on that edge.
- Throughput: one instruction per cycle when unstalled.
- Reset asserted mid-operation: immediate return to reset values, independent of clk. Deassertion takes effect at the next edge.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, add two outputs:
  - fetch_count (32 bits): increments on every edge that sets instr_valid=1.
  - bubble_count (32 bits): increments on every edge in RUN where a branch flushes or stall holds.
- Both counters reset to 0, saturate at 32'hFFFFFFFF, and freeze in HALT/FAULT.
- When undefined, neither port nor counter logic exists and all other behaviour is identical.

Test Plan:
- Reset then run with the default ROM image, no stall/branch:
  - Cycle after BOOT: instr=32'hf8000001, instr_pc=0, valid=1.
  - Next cycle: 32'hf8008002, instr_pc=4.
- Run to ROM index 47 (zero word):
  - Index 46 issues 32'hb400001f at instr_pc=0xB8.
  - Next edge: halted=1, valid=0.
  - Branch to 0 afterwards has no effect.
- Hold stall=1 for 3 cycles while instr=32'h8b050083 (instr_pc=0x0C): outputs are constant, imem_addr=4 holds. Release stall: next instr=32'hf8018003.
- Assert branch_taken and stall together, target=0x74:
  - Next edge: valid=0 (bubble).
  - Following edge (stall=0): instr=32'hb4000040, instr_pc=0x74.
- Branch to 0x102 (misaligned) and, separately after reset, to 0x100 (out of range): fault=1, valid=0 next edge; stays until reset.
- Pulse reset low mid-run between edges: outputs clear immediately. After release: BOOT cycle, then instr=32'hf8000001 at pc 0.

Source files
------------

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: owns the PC, addresses the instruction ROM and
// registers the fetched word for decode. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int unsigned  N               = 64,
  parameter int unsigned  IMEM_WORDS_LOG2 = 6,
  parameter logic [N-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [N-1:0]               branch_target,
  output logic [IMEM_WORDS_LOG2-1:0] imem_addr,
  input  logic [31:0]                imem_q,
  output logic [31:0]                instr,
  output logic [N-1:0]               instr_pc,
  output logic                       instr_valid,
  output logic                       halted,
  output logic                       fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                fetch_count,
  output logic [31:0]                bubble_count
`endif
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT,
    FAULT
  } state_t;

  localparam logic [N-1:0] ROM_BYTES = {{(N-1){1'b0}}, 1'b1} << (IMEM_WORDS_LOG2 + 2);
  localparam logic [N-1:0] PC_STEP   = {{(N-3){1'b0}}, 3'd4};

  state_t       state, state_n;
  logic [N-1:0] pc, pc_n;
  logic [31:0]  instr_n;
  logic [N-1:0] instr_pc_n;
  logic         instr_valid_n;
  logic         pc_oob;
  logic         tgt_bad;

  assign imem_addr = pc[IMEM_WORDS_LOG2+1:2];
  assign pc_oob    = (pc >= ROM_BYTES);
  assign tgt_bad   = (branch_target[1:0] != 2'b00) || (branch_target >= ROM_BYTES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      halted      <= (state_n == HALT);
      fault       <= (state_n == FAULT);
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    unique case (state)
      BOOT: begin
        state_n       = RUN;
        instr_valid_n = 1'b0;
      end
      RUN: begin
        // A redirect always wins; a concurrent stall is dropped so the bubble lands.
        if (branch_taken) begin
          instr_valid_n = 1'b0;
          if (tgt_bad) state_n = FAULT;
          else         pc_n    = branch_target;
        end else if (stall) begin
          // hold everything
        end else if (pc_oob) begin
          state_n       = FAULT;
          instr_valid_n = 1'b0;
        end else if (imem_q == '0) begin
          state_n       = HALT;
          instr_valid_n = 1'b0;
        end else begin
          instr_n       = imem_q;
          instr_pc_n    = pc;
          instr_valid_n = 1'b1;
          pc_n          = pc + PC_STEP;
        end
      end
      HALT: begin
        instr_valid_n = 1'b0;
      end
      FAULT: begin
        instr_valid_n = 1'b0;
      end
      default: begin
        state_n       = FAULT;
        instr_valid_n = 1'b0;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc;
  logic bubble_inc;

  always_comb begin
    fetch_inc  = (state == RUN) && !branch_taken && !stall && !pc_oob && (imem_q != '0);
    bubble_inc = (state == RUN) && (branch_taken ? !tgt_bad : stall);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (fetch_inc && (fetch_count != '1))   fetch_count  <= fetch_count + 32'd1;
      if (bubble_inc && (bubble_count != '1)) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: ROM image, abstract fetch model and directed scenarios.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic        fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  logic [31:0] rom [64];
  assign imem_q = rom[imem_addr];

  always #5 clk = ~clk;

  fetch_unit #(
    .N              (64),
    .IMEM_WORDS_LOG2(6),
    .RESET_PC       (64'h0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_q       (imem_q),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .fault        (fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a program counter walking the ROM image, with stop flags.
  logic [63:0] m_pc    = '0;
  logic [31:0] m_instr = '0;
  logic [63:0] m_ipc   = '0;
  bit          m_valid = 1'b0;
  bit          m_boot  = 1'b1;
  bit          m_halt  = 1'b0;
  bit          m_fault = 1'b0;
  int unsigned m_fetch = 0;
  int unsigned m_bubble = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = '0; m_instr = '0; m_ipc = '0; m_valid = 1'b0;
      m_boot = 1'b1; m_halt = 1'b0; m_fault = 1'b0; m_fetch = 0; m_bubble = 0;
    end else if (m_halt || m_fault) begin
      m_valid = 1'b0;
    end else if (m_boot) begin
      m_boot  = 1'b0;
      m_valid = 1'b0;
    end else if (branch_taken) begin
      m_valid = 1'b0;
      if ((branch_target % 4 != 0) || (branch_target >= 256)) m_fault = 1'b1;
      else begin
        m_pc = branch_target;
        m_bubble++;
      end
    end else if (stall) begin
      m_bubble++;
    end else if (m_pc >= 256) begin
      m_fault = 1'b1;
      m_valid = 1'b0;
    end else if (rom[int'(m_pc / 4)] == 32'h0) begin
      m_halt  = 1'b1;
      m_valid = 1'b0;
    end else begin
      m_instr = rom[int'(m_pc / 4)];
      m_ipc   = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 4;
      m_fetch++;
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      chk("m_instr",  64'(instr),       64'(m_instr));
      chk("m_ipc",    instr_pc,         m_ipc);
      chk("m_valid",  64'(instr_valid), 64'(m_valid));
      chk("m_halted", 64'(halted),      64'(m_halt));
      chk("m_fault",  64'(fault),       64'(m_fault));
      chk("m_addr",   64'(imem_addr),   64'(m_pc[7:2]));
`ifdef FETCH_PERF_CNT_EN
      chk("m_fetch_cnt",  64'(fetch_count),  64'(m_fetch));
      chk("m_bubble_cnt", 64'(bubble_count), 64'(m_bubble));
`endif
    end
  end

  task automatic wait_edge();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_instr", 64'(instr),       64'h0);
    chk("rst_ipc",   instr_pc,         64'h0);
    chk("rst_valid", 64'(instr_valid), 64'h0);
    chk("rst_halt",  64'(halted),      64'h0);
    chk("rst_fault", 64'(fault),       64'h0);
    chk("rst_addr",  64'(imem_addr),   64'h0);
    #1;
    reset = 1'b1;
  endtask

  task automatic boot_and_first();
    wait_edge();
    chk("boot_valid", 64'(instr_valid), 64'h0);
    wait_edge();
    chk("first_instr", 64'(instr), 64'hf8000001);
    chk("first_ipc",   instr_pc,   64'h0);
  endtask

  initial begin
    bit seen_b8;
    for (int i = 0; i < 64; i++) rom[i] = 32'h91000000 | 32'(i);
    rom[0]  = 32'hf8000001;
    rom[1]  = 32'hf8008002;
    rom[3]  = 32'h8b050083;
    rom[4]  = 32'hf8018003;
    rom[29] = 32'hb4000040;
    rom[46] = 32'hb400001f;
    rom[47] = 32'h00000000;

    #1 reset = 1'b0;
    #1 chk_on = 1'b1;
    #1;
    chk("init_instr", 64'(instr),       64'h0);
    chk("init_valid", 64'(instr_valid), 64'h0);
    chk("init_halt",  64'(halted),      64'h0);
    chk("init_fault", 64'(fault),       64'h0);
    @(negedge clk);
    reset = 1'b1;

    boot_and_first();
    chk("model_pin_first", 64'(m_instr), 64'hf8000001);
    wait_edge();
    chk("second_instr", 64'(instr), 64'hf8008002);
    chk("second_ipc",   instr_pc,   64'h4);
    wait_edge();
    wait_edge();
    chk("pre_stall_instr", 64'(instr),     64'h8b050083);
    chk("pre_stall_ipc",   instr_pc,       64'hc);
    chk("pre_stall_addr",  64'(imem_addr), 64'h4);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_edge();
      chk("stall_instr", 64'(instr),       64'h8b050083);
      chk("stall_ipc",   instr_pc,         64'hc);
      chk("stall_valid", 64'(instr_valid), 64'h1);
      chk("stall_addr",  64'(imem_addr),   64'h4);
    end
    stall = 1'b0;
    wait_edge();
    chk("post_stall_instr", 64'(instr), 64'hf8018003);
    chk("post_stall_ipc",   instr_pc,   64'h10);

    branch_taken = 1'b1; stall = 1'b1; branch_target = 64'h74;
    wait_edge();
    chk("br_bubble_valid", 64'(instr_valid), 64'h0);
    branch_taken = 1'b0; stall = 1'b0;
    wait_edge();
    chk("br_instr", 64'(instr), 64'hb4000040);
    chk("br_ipc",   instr_pc,   64'h74);
    chk("model_pin_br", m_ipc,  64'h74);

    seen_b8 = 1'b0;
    for (int i = 0; i < 40 && !halted; i++) begin
      wait_edge();
      if (instr_valid && instr_pc == 64'hb8) begin
        seen_b8 = 1'b1;
        chk("idx46_instr", 64'(instr), 64'hb400001f);
      end
    end
    chk("halt_reached", 64'(halted),      64'h1);
    chk("halt_valid",   64'(instr_valid), 64'h0);
    chk("idx46_seen",   64'(seen_b8),     64'h1);

    branch_taken = 1'b1; branch_target = 64'h0; stall = 1'b1;
    repeat (2) wait_edge();
    chk("halt_hold",      64'(halted),      64'h1);
    chk("halt_hold_vld",  64'(instr_valid), 64'h0);
    chk("halt_hold_flt",  64'(fault),       64'h0);
    chk("halt_hold_addr", 64'(imem_addr),   64'd47);
    branch_taken = 1'b0; stall = 1'b0;

    do_reset();
    boot_and_first();
    wait_edge();
    do_reset();
    boot_and_first();

    branch_taken = 1'b1; branch_target = 64'h102;
    wait_edge();
    chk("mis_fault", 64'(fault),       64'h1);
    chk("mis_valid", 64'(instr_valid), 64'h0);
    chk("mis_halt",  64'(halted),      64'h0);
    branch_target = 64'h0; stall = 1'b1;
    repeat (2) wait_edge();
    chk("mis_hold_fault", 64'(fault),       64'h1);
    chk("mis_hold_valid", 64'(instr_valid), 64'h0);
    branch_taken = 1'b0; stall = 1'b0;

    do_reset();
    boot_and_first();
    branch_taken = 1'b1; branch_target = 64'hfc;
    wait_edge();
    chk("last_bubble", 64'(instr_valid), 64'h0);
    branch_taken = 1'b0;
    wait_edge();
    chk("last_instr", 64'(instr),       64'h9100003f);
    chk("last_ipc",   instr_pc,         64'hfc);
    chk("last_valid", 64'(instr_valid), 64'h1);
    wait_edge();
    chk("wrap_fault", 64'(fault),       64'h1);
    chk("wrap_valid", 64'(instr_valid), 64'h0);
    chk("wrap_addr",  64'(imem_addr),   64'h0);

    do_reset();
    boot_and_first();
    branch_taken = 1'b1; branch_target = 64'h100;
    wait_edge();
    chk("oor_fault", 64'(fault),       64'h1);
    chk("oor_valid", 64'(instr_valid), 64'h0);
    branch_taken = 1'b0;
    repeat (2) wait_edge();
    chk("oor_hold", 64'(fault), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
